imm_gen_pipe: RTL and testbench

//  Buffered, parametrised immediate generator for the decode stage. Accepts instruction

---
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry result FIFO between fetch and decode.
// Optional compressed-instruction decode is enabled by defining IMMGEN_RVC_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_ir
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_ILL;
        if (in_ir[1:0] == 2'b11) begin
            case (in_ir[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
                end
                7'b0100011: begin
                    dec_fmt   = FMT_S;
                    dec_imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                end
                7'b1100011: begin
                    dec_fmt   = FMT_B;
                    dec_imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25],
                                 in_ir[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt   = FMT_U;
                    dec_imm32 = {in_ir[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec_fmt   = FMT_J;
                    dec_imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20],
                                 in_ir[30:21], 1'b0};
                end
                7'b0110011: dec_fmt = FMT_R;
                default:    dec_fmt = FMT_ILL;
            endcase
        end
`ifdef IMMGEN_RVC_EN
        else if (in_ir[1:0] == 2'b01) begin
            case (in_ir[15:13])
                3'b000, 3'b010: begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{26{in_ir[12]}}, in_ir[12], in_ir[6:2]};
                end
                3'b101: begin
                    dec_fmt   = FMT_J;
                    dec_imm32 = {{20{in_ir[12]}}, in_ir[12], in_ir[8], in_ir[10:9], in_ir[6],
                                 in_ir[7], in_ir[2], in_ir[11], in_ir[5:3], 1'b0};
                end
                3'b110, 3'b111: begin
                    dec_fmt   = FMT_B;
                    dec_imm32 = {{23{in_ir[12]}}, in_ir[12], in_ir[6:5], in_ir[2],
                                 in_ir[11:10], in_ir[4:3], 1'b0};
                end
                default: dec_fmt = FMT_ILL;
            endcase
        end
`endif
    end

    // Bit 31 of the 32-bit immediate is the sign for every format, so widen from it.
    assign dec_imm = {{(XLEN - 31){dec_imm32[31]}}, dec_imm32[30:0]};

    logic [XLEN-1:0] mem_imm [DEPTH];
    logic [2:0]      mem_fmt [DEPTH];
    logic [31:0]     mem_ir  [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rdy_en;
    logic [XLEN-1:0] hold_imm;
    logic [2:0]      hold_fmt;
    logic [31:0]     hold_ir;
    logic            push, pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = rdy_en && (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= '0;
                mem_ir[i]  <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_imm[wr_ptr] <= dec_imm;
                    mem_fmt[wr_ptr] <= dec_fmt;
                    mem_ir[wr_ptr]  <= in_ir;
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Shadow of the visible head so outputs keep their last value once the FIFO empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_imm <= '0;
            hold_fmt <= '0;
            hold_ir  <= '0;
        end else if (out_valid) begin
            hold_imm <= mem_imm[rd_ptr];
            hold_fmt <= mem_fmt[rd_ptr];
            hold_ir  <= mem_ir[rd_ptr];
        end
    end

    assign out_imm = out_valid ? mem_imm[rd_ptr] : hold_imm;
    assign out_fmt = out_valid ? mem_fmt[rd_ptr] : hold_fmt;
    assign out_ir  = out_valid ? mem_ir[rd_ptr]  : hold_ir;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/DEPTH=2 instance with a scoreboard, plus an XLEN=64 instance.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_ir, out_ir;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;

    logic        v64, rdy64, ov64, or64;
    logic [31:0] ir64, oir64;
    logic [63:0] oimm64;
    logic [2:0]  ofmt64;

    int checks = 0;
    int errors = 0;
    logic [66:0] exp_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_ir(out_ir)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(3)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v64), .in_ready(rdy64), .in_ir(ir64),
        .out_valid(ov64), .out_ready(or64),
        .out_imm(oimm64), .out_fmt(ofmt64), .out_ir(oir64)
    );

    // Reference decode written straight from the instruction-set field layouts.
    function automatic logic [66:0] model(input logic [31:0] ir);
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [6:0]  op;
        imm = 32'd0;
        fmt = 3'd7;
        op  = ir[6:0];
        if (ir[1:0] == 2'b11) begin
            if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
                fmt = 3'd1; imm = 32'(signed'(ir[31:20]));
            end else if (op == 7'h23) begin
                fmt = 3'd2; imm = 32'(signed'({ir[31:25], ir[11:7]}));
            end else if (op == 7'h63) begin
                fmt = 3'd3; imm = 32'(signed'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            end else if (op == 7'h37 || op == 7'h17) begin
                fmt = 3'd4; imm = {ir[31:12], 12'h000};
            end else if (op == 7'h6F) begin
                fmt = 3'd5; imm = 32'(signed'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            end else if (op == 7'h33) begin
                fmt = 3'd0;
            end
        end
`ifdef IMMGEN_RVC_EN
        else if (ir[1:0] == 2'b01) begin
            if (ir[15:13] == 3'b000 || ir[15:13] == 3'b010) begin
                fmt = 3'd1; imm = 32'(signed'({ir[12], ir[6:2]}));
            end else if (ir[15:13] == 3'b101) begin
                fmt = 3'd5;
                imm = 32'(signed'({ir[12], ir[8], ir[10:9], ir[6], ir[7], ir[2], ir[11],
                                   ir[5:3], 1'b0}));
            end else if (ir[15:14] == 2'b11) begin
                fmt = 3'd3;
                imm = 32'(signed'({ir[12], ir[6:5], ir[2], ir[11:10], ir[4:3], 1'b0}));
            end
        end
`endif
        return {imm, fmt, ir};
    endfunction

    // Scoreboard: inputs are stable here, so record accepted words and retire popped heads.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got ir=%h imm=%h fmt=%0d, required no output",
                             out_ir, out_imm, out_fmt);
                end else begin
                    logic [66:0] e;
                    e = exp_q.pop_front();
                    if ({out_imm, out_fmt, out_ir} !== e) begin
                        errors++;
                        $display("FAIL sb_head: got imm=%h fmt=%0d ir=%h, required imm=%h fmt=%0d ir=%h",
                                 out_imm, out_fmt, out_ir, e[66:35], e[34:32], e[31:0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_ir));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic rdy);
        in_valid  = v;
        in_ir     = ir;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        v64 = 1'b0; ir64 = 32'h0; or64 = 1'b1;
        #3;
        checks++;
        if ({out_valid, out_imm, out_fmt, out_ir} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b imm=%h fmt=%0d ir=%h, required all 0",
                     out_valid, out_imm, out_fmt, out_ir);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'hFFF00093, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 ||
            out_ir !== 32'hFFF00093) begin
            errors++;
            $display("FAIL single_addi: got v=%b imm=%h fmt=%0d ir=%h, required 1 ffffffff 1 fff00093",
                     out_valid, out_imm, out_fmt, out_ir);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1) begin
            errors++;
            $display("FAIL single_hold: got v=%b imm=%h fmt=%0d, required 0 ffffffff 1",
                     out_valid, out_imm, out_fmt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        logic [31:0] ei [3];
        logic [2:0]  ef [3];
        w  = '{32'hFE20AE23, 32'h123452B7, 32'h00000463};
        ei = '{32'hFFFFFFFC, 32'h12345000, 32'h00000008};
        ef = '{3'd2, 3'd4, 3'd3};
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) drive(1'b1, w[i], 1'b1);
            else       in_valid = 1'b0;
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_imm !== ei[i-1] || out_fmt !== ef[i-1]) begin
                    errors++;
                    $display("FAIL b2b_%0d: got v=%b imm=%h fmt=%0d, required 1 %h %0d",
                             i - 1, out_valid, out_imm, out_fmt, ei[i-1], ef[i-1]);
                end
            end
            if (i < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_%0d: got in_ready=%b, required 1", i, in_ready);
                end
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 32'h00A00513, 1'b0);
        tick();
        in_ir = 32'h00C0006F;
        tick();
        in_ir = 32'h00000033;
        checks++;
        if (in_ready !== 1'b0 || out_ir !== 32'h00A00513 || out_imm !== 32'd10) begin
            errors++;
            $display("FAIL full_ready: got in_ready=%b ir=%h imm=%h, required 0 00a00513 0000000a",
                     in_ready, out_ir, out_imm);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_held: got in_ready=%b, required 0", in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_ir !== 32'h00C0006F || out_imm !== 32'd12 || out_fmt !== 3'd5) begin
            errors++;
            $display("FAIL full_second: got in_ready=%b ir=%h imm=%h fmt=%0d, required 1 00c0006f 0000000c 5",
                     in_ready, out_ir, out_imm, out_fmt);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ir !== 32'h00000033 || out_imm !== 32'd0 || out_fmt !== 3'd0) begin
            errors++;
            $display("FAIL full_third: got v=%b ir=%h imm=%h fmt=%0d, required 1 00000033 0 0",
                     out_valid, out_ir, out_imm, out_fmt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        for (int n = 1; n <= 2; n++) begin
            drive(1'b1, 32'h00100093, 1'b0);
            for (int k = 0; k < n; k++) tick();
            in_ir = 32'h7FF00113;
            flush = 1'b1;
            tick();
            flush = 1'b0;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL flush_%0d: got out_valid=%b in_ready=%b, required 0/1",
                         n, out_valid, in_ready);
            end
            out_ready = 1'b1;
            tick(); tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop_%0d: got out_valid=%b ir=%h, required 0", n, out_valid, out_ir);
            end
        end
        drive(1'b1, 32'h00500193, 1'b0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_imm, out_fmt, out_ir} !== 68'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b imm=%h fmt=%0d ir=%h, required all 0",
                     out_valid, out_imm, out_fmt, out_ir);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_rvc();
        logic [31:0] ei;
        logic [2:0]  ef;
`ifdef IMMGEN_RVC_EN
        ei = 32'hFFFFFFFF; ef = 3'd1;
`else
        ei = 32'h00000000; ef = 3'd7;
`endif
        drive(1'b1, 32'h0000557D, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== ei || out_fmt !== ef) begin
            errors++;
            $display("FAIL rvc_cli: got v=%b imm=%h fmt=%0d, required 1 %h %0d",
                     out_valid, out_imm, out_fmt, ei, ef);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h01, 7'h02};
        for (int c = 0; c < 400; c++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            drive(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 2) != 0));
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 20 && out_valid; c++) tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got out_valid=%b pending=%0d, required 0/0",
                     out_valid, exp_q.size());
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] w [3];
        logic [63:0] ei [3];
        logic [2:0]  ef [3];
        w  = '{32'hFFF00093, 32'h800002B7, 32'h0000007F};
        ei = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h0};
        ef = '{3'd1, 3'd4, 3'd7};
        for (int i = 0; i < 3; i++) begin
            v64 = 1'b1; ir64 = w[i];
            tick();
            v64 = 1'b0;
            checks++;
            if (ov64 !== 1'b1 || oimm64 !== ei[i] || ofmt64 !== ef[i] || oir64 !== w[i]) begin
                errors++;
                $display("FAIL x64_%0d: got v=%b imm=%h fmt=%0d ir=%h, required 1 %h %0d %h",
                         i, ov64, oimm64, ofmt64, oir64, ei[i], ef[i], w[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_flush();
        test_rvc();
        test_xlen64();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
